gray_binary_updown_counter: RTL and testbench
=============================================

// Module: gray_binary_updown_counter
// PURPOSE
//   Parametrised WIDTH-bit counter. Counts in plain binary or reflected Gray code,
//   up or down, with enable and synchronous load.
//   Also provides odd parity of the count register, the binary-equivalent value,
//   and a one-cycle wrap pulse.
//   Next generation of our fixed 3-bit binary/Gray counter FSM. Used as a sequence
//   generator and position counter in the FSM datapaths.
// PARAMETERS
//   WIDTH        3   count register width in bits; legal range 2..16
//   RESET_VALUE  0   raw register value loaded on reset (WIDTH bits, taken as-is)
// PORTS
//   clk         in   1      rising-edge clock
//   reset_n     in   1      asynchronous reset, active-low
//   en          in   1      advance one step on this edge when high
//   mode_gray   in   1      0 = binary sequence, 1 = Gray sequence
//   dir_down    in   1      0 = count up, 1 = count down
//   load        in   1      synchronous load; has priority over en
//   load_value  in   WIDTH  raw register value written on load
//   count       out  WIDTH  count register (raw code: binary or Gray)
//   bin_value   out  WIDTH  gray2bin(count) if mode_gray=1, else count (combinational)
//   parity      out  1      XOR-reduction of count (combinational); 1 = odd number of ones
//   wrap        out  1      registered one-cycle pulse: the previous edge stepped across the end
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous)
//     - count = RESET_VALUE, wrap = 0; held for as long as reset_n = 0.
//     - Release is synchronous to the next rising clk edge.
//     - Reset during counting discards the step in progress; no wrap pulse is produced.
//   Priority on each rising edge: reset > load > en > hold.
//     - load=1: count <= load_value; wrap <= 0; en, mode_gray and dir_down are ignored.
//     - en=1, load=0: count <= step(count); wrap <= wrapped.
//     - otherwise: count holds; wrap <= 0.
//   Binary mode (mode_gray=0)
//     - step = count +/- 1, modulo 2^WIDTH.
//     - wrapped = (up && count = all-ones) || (down && count = 0).
//   Gray mode (mode_gray=1)
//     - b = gray2bin(count); b' = b +/- 1 modulo 2^WIDTH; step = bin2gray(b').
//     - gray2bin: b[W-1] = g[W-1], b[i] = b[i+1] ^ g[i].
//     - bin2gray: g = b ^ (b >> 1).
//     - wrapped = (up && b = all-ones) || (down && b = 0).
//   Mode and direction changes
//     - Sampled on the same edge as en; no state conversion is performed.
//     - The existing register is reinterpreted in the new code.
//     - Example: binary 011 switched to Gray steps to 010.
//   Latency
//     - count changes on the edge that samples en/load.
//     - wrap is high for exactly the cycle following a wrapping step.
//     - parity and bin_value follow count with zero cycles of latency (combinational).
//   Gray mode guarantee: each enabled step changes exactly one bit of count;
//   parity therefore toggles on every enabled step.
//   No X propagation: every register has a defined reset value; no latches.
// TESTING  (WIDTH=3, RESET_VALUE=0 unless noted)
//   1. Gray up
//      - Stimulus: reset; en=1, mode_gray=1, dir_down=0 for 9 clocks.
//      - Required: count = 001,011,010,110,111,101,100,000,001.
//      - Required: wrap=1 only in the cycle after 100->000.
//      - Required: parity alternates 1,0,1,0,...
//   2. Binary down wrap
//      - Stimulus: reset; en=1, mode_gray=0, dir_down=1.
//      - Required: count = 7,6,5.
//      - Required: wrap=1 in the cycle after 0->7 only.
//      - Required: bin_value equals count throughout.
//   3. Mode switch
//      - Stimulus: binary up to count=011, then set mode_gray=1.
//      - Required: next counts 010, 110.
//      - Required: bin_value shows 3, then 4.
//      - Required: parity = 0, 1, 0.
//   4. Load priority
//      - Stimulus: load=1, en=1, load_value=101.
//      - Required: count=101, wrap=0.
//      - Stimulus: next cycle, load=0, Gray down.
//      - Required: count = 111 (b 6->5 gives Gray 111).
//   5. Hold and asynchronous reset
//      - Stimulus: en=0 for 4 clocks.
//      - Required: count and wrap stable, wrap=0.
//      - Stimulus: assert reset_n=0 between clock edges.
//      - Required: count=000 immediately, without waiting for an edge.
//   6. WIDTH=8, RESET_VALUE=8'hFE
//      - Stimulus: binary up, en=1.
//      - Required: count = FF then 00; wrap=1 in the cycle after the FF->00 step.
//      - Stimulus: Gray up 256 steps.
//      - Required: every step changes exactly one bit; count returns to its start value.

Source files
------------

// File: rtl/gray_binary_updown_counter.sv
// ---------------------------------------------------------------------------
// gray_binary_updown_counter
//   WIDTH-bit up/down counter that steps either in plain binary or in
//   reflected Gray code. It has an enable, a synchronous load that beats the
//   enable, and asynchronous active-low reset.
//   A mode or direction change does not convert the register. The raw value
//   is read in the newly selected code and stepped from there.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous reset, active-low
//   en         in   1      advance one step on this edge
//   mode_gray  in   1      0 = binary, 1 = Gray
//   dir_down   in   1      0 = up, 1 = down
//   load       in   1      synchronous load (priority over en)
//   load_value in   WIDTH  raw value written on load
//   count      out  WIDTH  count register (raw code)
//   bin_value  out  WIDTH  binary equivalent of count in the current mode
//   parity     out  1      XOR-reduction of count
//   wrap       out  1      one-cycle pulse after a step across the end
// ---------------------------------------------------------------------------
module gray_binary_updown_counter #(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             mode_gray,
  input  logic             dir_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] bin_value,
  output logic             parity,
  output logic             wrap
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH-1:0] w_g2b;     // count decoded as Gray
  logic [WIDTH-1:0] w_base;    // count as a binary ordinal in the current mode
  logic [WIDTH-1:0] w_next_b;  // ordinal after one step
  logic [WIDTH-1:0] w_step;    // next raw register value
  logic             w_wrapped;

  // Each bit of gray2bin is the XOR of all Gray bits at or above it.
  // Computing the bits independently avoids a combinational chain that
  // reads its own output.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_g2b
      assign w_g2b[gi] = ^(r_count >> gi);
    end
  endgenerate

  assign w_base    = mode_gray ? w_g2b : r_count;
  assign w_next_b  = dir_down ? (w_base - WIDTH'(1)) : (w_base + WIDTH'(1));
  assign w_step    = mode_gray ? (w_next_b ^ (w_next_b >> 1)) : w_next_b;
  assign w_wrapped = dir_down ? (w_base == '0) : (w_base == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= RESET_VALUE;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= load_value;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_count <= w_step;
      r_wrap  <= w_wrapped;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count     = r_count;
  assign bin_value = w_base;
  assign parity    = ^r_count;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_gray_binary_updown_counter.sv
module tb_gray_binary_updown_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 3-bit instance
  logic       rst3_n, en3, mg3, dd3, ld3;
  logic [2:0] lv3, cnt3, bin3;
  logic       par3, wrp3;

  // 8-bit instance
  logic       rst8_n, en8, mg8, dd8, ld8;
  logic [7:0] lv8, cnt8, bin8;
  logic       par8, wrp8;

  int checks = 0;
  int errors = 0;

  gray_binary_updown_counter #(.WIDTH(3), .RESET_VALUE(3'b000)) u3 (
    .clk(clk), .reset_n(rst3_n), .en(en3), .mode_gray(mg3), .dir_down(dd3),
    .load(ld3), .load_value(lv3), .count(cnt3), .bin_value(bin3),
    .parity(par3), .wrap(wrp3)
  );

  gray_binary_updown_counter #(.WIDTH(8), .RESET_VALUE(8'hFE)) u8 (
    .clk(clk), .reset_n(rst8_n), .en(en8), .mode_gray(mg8), .dir_down(dd8),
    .load(ld8), .load_value(lv8), .count(cnt8), .bin_value(bin8),
    .parity(par8), .wrap(wrp8)
  );

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reset the 3-bit instance, release between edges
  task automatic reset3();
    en3 = 0; ld3 = 0; mg3 = 0; dd3 = 0; lv3 = '0;
    rst3_n = 0;
    tick();
    #3 rst3_n = 1;
  endtask

  task automatic test_reset();
    rst3_n = 1; rst8_n = 1;
    en3 = 0; ld3 = 0; mg3 = 0; dd3 = 0; lv3 = '0;
    en8 = 0; ld8 = 0; mg8 = 0; dd8 = 0; lv8 = '0;
    #2 rst3_n = 0; rst8_n = 0;
    #1;
    checks++; if (cnt3 !== 3'b000) begin errors++; $display("FAIL reset_count3: got %b expected 000", cnt3); end
    checks++; if (wrp3 !== 1'b0)   begin errors++; $display("FAIL reset_wrap3: got %b expected 0", wrp3); end
    checks++; if (cnt8 !== 8'hFE)  begin errors++; $display("FAIL reset_count8: got %h expected fe", cnt8); end
    checks++; if (wrp8 !== 1'b0)   begin errors++; $display("FAIL reset_wrap8: got %b expected 0", wrp8); end
    tick();
    #3 rst3_n = 1; rst8_n = 1;
  endtask

  task automatic test_gray_up();
    logic [2:0] exp_c [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                              3'b101, 3'b100, 3'b000, 3'b001};
    reset3();
    en3 = 1; mg3 = 1; dd3 = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (cnt3 !== exp_c[i]) begin errors++; $display("FAIL gray_up_count[%0d]: got %b expected %b", i, cnt3, exp_c[i]); end
      checks++; if (wrp3 !== (i == 7)) begin errors++; $display("FAIL gray_up_wrap[%0d]: got %b expected %b", i, wrp3, (i == 7)); end
      checks++; if (par3 !== ((i % 2) == 0)) begin errors++; $display("FAIL gray_up_parity[%0d]: got %b expected %b", i, par3, ((i % 2) == 0)); end
    end
    en3 = 0;
  endtask

  task automatic test_binary_down();
    logic [2:0] exp_c [3] = '{3'd7, 3'd6, 3'd5};
    reset3();
    en3 = 1; mg3 = 0; dd3 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cnt3 !== exp_c[i]) begin errors++; $display("FAIL bin_down_count[%0d]: got %0d expected %0d", i, cnt3, exp_c[i]); end
      checks++; if (bin3 !== exp_c[i]) begin errors++; $display("FAIL bin_down_binval[%0d]: got %0d expected %0d", i, bin3, exp_c[i]); end
      checks++; if (wrp3 !== (i == 0)) begin errors++; $display("FAIL bin_down_wrap[%0d]: got %b expected %b", i, wrp3, (i == 0)); end
    end
    en3 = 0;
  endtask

  task automatic test_mode_switch();
    reset3();
    en3 = 1; mg3 = 0; dd3 = 0;
    tick(); tick(); tick();
    checks++; if (cnt3 !== 3'b011) begin errors++; $display("FAIL mode_pre_count: got %b expected 011", cnt3); end
    checks++; if (bin3 !== 3'd3)   begin errors++; $display("FAIL mode_pre_binval: got %0d expected 3", bin3); end
    checks++; if (par3 !== 1'b0)   begin errors++; $display("FAIL mode_pre_parity: got %b expected 0", par3); end
    mg3 = 1;
    tick();
    checks++; if (cnt3 !== 3'b010) begin errors++; $display("FAIL mode_sw_count0: got %b expected 010", cnt3); end
    checks++; if (bin3 !== 3'd3)   begin errors++; $display("FAIL mode_sw_binval0: got %0d expected 3", bin3); end
    checks++; if (par3 !== 1'b1)   begin errors++; $display("FAIL mode_sw_parity0: got %b expected 1", par3); end
    tick();
    checks++; if (cnt3 !== 3'b110) begin errors++; $display("FAIL mode_sw_count1: got %b expected 110", cnt3); end
    checks++; if (bin3 !== 3'd4)   begin errors++; $display("FAIL mode_sw_binval1: got %0d expected 4", bin3); end
    checks++; if (par3 !== 1'b0)   begin errors++; $display("FAIL mode_sw_parity1: got %b expected 0", par3); end
    en3 = 0;
  endtask

  task automatic test_load_priority();
    // park at binary all-ones so an enabled up step would wrap to 000
    en3 = 0; ld3 = 1; lv3 = 3'b111; mg3 = 0; dd3 = 0;
    tick();
    checks++; if (cnt3 !== 3'b111) begin errors++; $display("FAIL load_park: got %b expected 111", cnt3); end
    en3 = 1; ld3 = 1; lv3 = 3'b101;
    tick();
    checks++; if (cnt3 !== 3'b101) begin errors++; $display("FAIL load_prio_count: got %b expected 101", cnt3); end
    checks++; if (wrp3 !== 1'b0)   begin errors++; $display("FAIL load_prio_wrap: got %b expected 0", wrp3); end
    ld3 = 0; mg3 = 1; dd3 = 1;
    tick();
    checks++; if (cnt3 !== 3'b111) begin errors++; $display("FAIL load_gray_down: got %b expected 111", cnt3); end
    en3 = 0;
  endtask

  task automatic test_hold_async_reset();
    en3 = 0; ld3 = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (cnt3 !== 3'b111) begin errors++; $display("FAIL hold_count[%0d]: got %b expected 111", i, cnt3); end
      checks++; if (wrp3 !== 1'b0)   begin errors++; $display("FAIL hold_wrap[%0d]: got %b expected 0", i, wrp3); end
    end
    // mid-cycle reset takes effect without a clock edge
    #2 rst3_n = 0;
    #1;
    checks++; if (cnt3 !== 3'b000) begin errors++; $display("FAIL async_reset_count: got %b expected 000", cnt3); end
    // enabled edge while reset is held must not step
    en3 = 1; mg3 = 0; dd3 = 0;
    tick();
    checks++; if (cnt3 !== 3'b000) begin errors++; $display("FAIL reset_hold_count: got %b expected 000", cnt3); end
    #3 rst3_n = 1;
    en3 = 0;
    // wrapping step, then reset must clear the pulse immediately
    ld3 = 1; lv3 = 3'b111;
    tick();
    ld3 = 0; en3 = 1;
    tick();
    checks++; if (wrp3 !== 1'b1)   begin errors++; $display("FAIL pre_reset_wrap: got %b expected 1", wrp3); end
    #2 rst3_n = 0;
    #1;
    checks++; if (wrp3 !== 1'b0)   begin errors++; $display("FAIL async_reset_wrap: got %b expected 0", wrp3); end
    en3 = 0;
    tick();
    #3 rst3_n = 1;
  endtask

  task automatic test_wide_binary();
    en8 = 1; mg8 = 0; dd8 = 0; ld8 = 0;
    tick();
    checks++; if (cnt8 !== 8'hFF) begin errors++; $display("FAIL w8_count0: got %h expected ff", cnt8); end
    checks++; if (wrp8 !== 1'b0)  begin errors++; $display("FAIL w8_wrap0: got %b expected 0", wrp8); end
    tick();
    checks++; if (cnt8 !== 8'h00) begin errors++; $display("FAIL w8_count1: got %h expected 00", cnt8); end
    checks++; if (wrp8 !== 1'b1)  begin errors++; $display("FAIL w8_wrap1: got %b expected 1", wrp8); end
    tick();
    checks++; if (cnt8 !== 8'h01) begin errors++; $display("FAIL w8_count2: got %h expected 01", cnt8); end
    checks++; if (wrp8 !== 1'b0)  begin errors++; $display("FAIL w8_wrap2: got %b expected 0", wrp8); end
    en8 = 0;
  endtask

  task automatic test_wide_gray();
    logic [7:0] start, prev;
    logic       prev_par;
    int         nwrap = 0;
    int         bad_one_bit = 0;
    int         bad_par = 0;
    start = cnt8;
    prev = cnt8;
    prev_par = par8;
    en8 = 1; mg8 = 1; dd8 = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 0) begin
        // raw 01 read as Gray is ordinal 1; ordinal 2 encodes as 03
        checks++; if (cnt8 !== 8'h03) begin errors++; $display("FAIL w8_gray_first: got %h expected 03", cnt8); end
      end
      if ($countones(cnt8 ^ prev) != 1) bad_one_bit++;
      if (par8 === prev_par) bad_par++;
      if (wrp8 === 1'b1) nwrap++;
      prev = cnt8;
      prev_par = par8;
    end
    en8 = 0;
    checks++; if (bad_one_bit != 0) begin errors++; $display("FAIL w8_gray_one_bit: got %0d bad steps expected 0", bad_one_bit); end
    checks++; if (bad_par != 0)     begin errors++; $display("FAIL w8_gray_parity: got %0d bad steps expected 0", bad_par); end
    checks++; if (nwrap != 1)       begin errors++; $display("FAIL w8_gray_wraps: got %0d expected 1", nwrap); end
    checks++; if (cnt8 !== start)   begin errors++; $display("FAIL w8_gray_return: got %h expected %h", cnt8, start); end
  endtask

  initial begin
    test_reset();
    test_gray_up();
    test_binary_down();
    test_mode_switch();
    test_load_priority();
    test_hold_async_reset();
    test_wide_binary();
    test_wide_gray();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
